// File: rtl/singcyc_periph_if.sv
// rtl/singcyc_periph_if.sv - data-memory bus between the single-cycle core and the peripheral block
//
// Purpose: groups the core's data-port address, strobes and data buses.
// Members:
//   iAddr     - byte address from the core (ALU result)
//   iMemRead  - read strobe
//   iMemWrite - write strobe, sampled on the rising clock edge
//   iWrData   - write data
//   oRdData   - combinational read data returned by the peripheral
// Modports: master (core side), slave (peripheral side).
interface singcyc_periph_if;
    logic [31:0] iAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iWrData;
    logic [31:0] oRdData;

    modport master (
        output iAddr,
        output iMemRead,
        output iMemWrite,
        output iWrData,
        input  oRdData
    );

    modport slave (
        input  iAddr,
        input  iMemRead,
        input  iMemWrite,
        input  iWrData,
        output oRdData
    );
endinterface

// File: rtl/singcyc_periph.sv
// rtl/singcyc_periph.sv - memory-mapped timer, LED/switch/7-seg and UART TX peripheral
//
// Purpose: decodes the 32-byte register window at BASE_ADDR on the core's data port.
//   0x00 TH, 0x04 TL, 0x08 TCON[2:0], 0x0C LED[7:0], 0x10 SWITCH (RO),
//   0x14 DIGI[11:0], 0x18 UART_TXD (WO), 0x1C UART_STAT (RO, bit0 = busy).
// Ports:
//   iClk, iRst_n - clock, asynchronous active-low reset
//   bus          - data-memory slave port (address, strobes, write/read data)
//   iSwitch      - board switches
//   oLed, oDigi  - LED and 7-seg drive registers
//   oTx          - UART serial output, idle high
//   oIrq         - timer interrupt request (TCON[2])
module singcyc_periph #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h40000000
) (
    input  logic            iClk,
    input  logic            iRst_n,
    singcyc_periph_if.slave bus,
    input  logic [7:0]      iSwitch,
    output logic [7:0]      oLed,
    output logic [11:0]     oDigi,
    output logic            oTx,
    output logic            oIrq
);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] SEL_TH   = 3'd0;
    localparam logic [2:0] SEL_TL   = 3'd1;
    localparam logic [2:0] SEL_TCON = 3'd2;
    localparam logic [2:0] SEL_LED  = 3'd3;
    localparam logic [2:0] SEL_SW   = 3'd4;
    localparam logic [2:0] SEL_DIGI = 3'd5;
    localparam logic [2:0] SEL_TXD  = 3'd6;
    localparam logic [2:0] SEL_STAT = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;

    uart_state_t state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;

    // Subtracting the base gives a full 32-bit compare for any base alignment.
    logic [31:0] off;
    logic        mapped;
    logic [2:0]  sel;
    logic        wr_en;
    logic [31:0] rd_data;

    assign off    = bus.iAddr - BASE_ADDR;
    assign mapped = (off[31:5] == 27'd0) && (off[1:0] == 2'b00);
    assign sel    = off[4:2];
    assign wr_en  = bus.iMemWrite && mapped;

    always_comb begin
        rd_data = 32'd0;
        if (bus.iMemRead && mapped) begin
            case (sel)
                SEL_TH:   rd_data = th_q;
                SEL_TL:   rd_data = tl_q;
                SEL_TCON: rd_data = {29'd0, tcon_q};
                SEL_LED:  rd_data = {24'd0, led_q};
                SEL_SW:   rd_data = {24'd0, iSwitch};
                SEL_DIGI: rd_data = {20'd0, digi_q};
                SEL_TXD:  rd_data = 32'd0;
                SEL_STAT: rd_data = {31'd0, busy_q};
                default:  rd_data = 32'd0;
            endcase
        end
    end

    assign bus.oRdData = rd_data;

    // Timer update is computed first so a same-cycle CPU write overrides it;
    // a reload always uses the TH value held before this edge.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;
        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFFFFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wr_en) begin
            case (sel)
                SEL_TH:   th_d   = bus.iWrData;
                SEL_TL:   tl_d   = bus.iWrData;
                SEL_TCON: tcon_d = bus.iWrData[2:0];
                SEL_LED:  led_d  = bus.iWrData[7:0];
                SEL_DIGI: digi_d = bus.iWrData[11:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'd0;
            led_q  <= 8'd0;
            digi_q <= 12'd0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

    // UART transmitter. A TXD write is only accepted in IDLE, so writes while
    // busy, including the final STOP cycle, are dropped.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_en && (sel == SEL_TXD)) begin
                        shift_q <= bus.iWrData[7:0];
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= 16'd0;
                    end
                end
                S_START: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= 16'd0;
                        idx_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= 16'd0;
                        if (idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= 16'd0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oLed  = led_q;
    assign oDigi = digi_q;
    assign oTx   = tx_q;
    assign oIrq  = tcon_q[2];
endmodule

// File: tb/tb_singcyc_periph.sv
// tb/tb_singcyc_periph.sv - self-checking bench for singcyc_periph
module tb_singcyc_periph;
    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h40000000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_SW   = BASE + 32'h10;
    localparam logic [31:0] A_DIGI = BASE + 32'h14;
    localparam logic [31:0] A_TXD  = BASE + 32'h18;
    localparam logic [31:0] A_STAT = BASE + 32'h1C;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [7:0]  iSwitch;
    logic [7:0]  oLed;
    logic [11:0] oDigi;
    logic        oTx;
    logic        oIrq;

    singcyc_periph_if bus ();

    singcyc_periph #(.CLKS_PER_BIT(N), .BASE_ADDR(BASE)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .bus     (bus),
        .iSwitch (iSwitch),
        .oLed    (oLed),
        .oDigi   (oDigi),
        .oTx     (oTx),
        .oIrq    (oIrq)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_th = 0, m_tl = 0;
    logic [2:0]  m_tcon = 0;
    logic [7:0]  m_led = 0;
    logic [11:0] m_digi = 0;
    int          ec = 0;        // clock edges seen since time zero
    bit          u_active = 0;
    int          u_t0 = 0;      // edge count at which the first START cycle begins
    logic [7:0]  u_byte = 0;

    function automatic bit m_busy();
        return u_active && ((ec - u_t0) < 10 * N);
    endfunction

    function automatic logic m_tx();
        int p;
        if (!m_busy()) return 1'b1;
        p = (ec - u_t0) / N;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return u_byte[p-1];
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] addr, input logic rd);
        logic [31:0] off;
        off = addr - BASE;
        if (!rd || off >= 32 || off[1:0] != 2'b00) return 32'd0;
        case (off)
            32'h00: return m_th;
            32'h04: return m_tl;
            32'h08: return {29'd0, m_tcon};
            32'h0C: return {24'd0, m_led};
            32'h10: return {24'd0, iSwitch};
            32'h14: return {20'd0, m_digi};
            32'h1C: return {31'd0, m_busy()};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge iClk or negedge iRst_n) begin
        logic [31:0] off, n_tl;
        logic [2:0]  n_tcon;
        bit          bz, hit;
        if (!iRst_n) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; u_active = 0;
        end else begin
            off    = bus.iAddr - BASE;
            hit    = bus.iMemWrite && off < 32 && off[1:0] == 2'b00;
            bz     = m_busy();
            n_tl   = m_tl;
            n_tcon = m_tcon;
            if (m_tcon[0]) begin
                if (m_tl == 32'hFFFFFFFF) begin
                    n_tl = m_th;
                    if (m_tcon[1]) n_tcon[2] = 1'b1;
                end else begin
                    n_tl = m_tl + 1;
                end
            end
            if (hit) begin
                case (off)
                    32'h00: m_th = bus.iWrData;
                    32'h04: n_tl = bus.iWrData;
                    32'h08: n_tcon = bus.iWrData[2:0];
                    32'h0C: m_led = bus.iWrData[7:0];
                    32'h14: m_digi = bus.iWrData[11:0];
                    32'h18: if (!bz) begin
                        u_active = 1; u_t0 = ec + 1; u_byte = bus.iWrData[7:0];
                    end
                    default: ;
                endcase
            end
            m_tl   = n_tl;
            m_tcon = n_tcon;
            ec++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge iClk) begin
        chk("led",   {24'd0, oLed},  {24'd0, m_led});
        chk("digi",  {20'd0, oDigi}, {20'd0, m_digi});
        chk("irq",   {31'd0, oIrq},  {31'd0, m_tcon[2]});
        chk("tx",    {31'd0, oTx},   {31'd0, m_tx()});
        chk("rdata", bus.oRdData,    m_rd(bus.iAddr, bus.iMemRead));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.iAddr = a; bus.iWrData = d; bus.iMemWrite = 1'b1; bus.iMemRead = 1'b0;
        step();
        bus.iMemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.iAddr = a; bus.iMemRead = 1'b1; bus.iMemWrite = 1'b0;
        #1;
        d = bus.oRdData;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 11))
            8:  return BASE + 32'h20;
            9:  return BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(1, 3));
            10: return BASE - 32'd4;
            11: return $urandom();
            default: return BASE + 32'($urandom_range(0, 7)) * 4;
        endcase
    endfunction

    logic [31:0] r;
    logic [9:0]  pat55;
    logic [9:0]  pat0f;

    initial begin
        pat55 = 10'b1010101010;   // bit i = level during frame bit i (start first)
        pat0f = 10'b1000011110;
        iRst_n = 1'b0;
        iSwitch = 8'hA5;
        bus.iAddr = 32'd0; bus.iMemRead = 1'b0; bus.iMemWrite = 1'b0; bus.iWrData = 32'd0;
        repeat (3) step();
        iRst_n = 1'b1;
        step();

        // Reset values
        rd(A_TH, r);   chk("rst_th", r, 32'd0);   step();
        rd(A_TL, r);   chk("rst_tl", r, 32'd0);   step();
        rd(A_TCON, r); chk("rst_tcon", r, 32'd0); step();
        rd(A_LED, r);  chk("rst_led", r, 32'd0);  step();
        rd(A_DIGI, r); chk("rst_digi", r, 32'd0); step();
        rd(A_STAT, r); chk("rst_stat", r, 32'd0);
        chk("rst_tx", {31'd0, oTx}, 32'd1);
        chk("rst_irq", {31'd0, oIrq}, 32'd0);
        rd(A_SW, r);   chk("switch_a5", r, 32'h000000A5);
        bus.iMemRead = 1'b0; #1;
        chk("read_strobe_off", bus.oRdData, 32'd0);
        step();

        // Timer reload with interrupt
        wr(A_TH, 32'hFFFFFFFD);
        wr(A_TL, 32'hFFFFFFFE);
        wr(A_TCON, 32'd3);
        rd(A_TL, r); chk("tl_after_en", r, 32'hFFFFFFFE);
        step(); rd(A_TL, r); chk("tl_1cyc", r, 32'hFFFFFFFF);
        chk("irq_before", {31'd0, oIrq}, 32'd0);
        step(); rd(A_TL, r); chk("tl_reload", r, 32'hFFFFFFFD);
        chk("irq_set", {31'd0, oIrq}, 32'd1);
        wr(A_TCON, 32'd3);
        chk("irq_clear", {31'd0, oIrq}, 32'd0);
        wr(A_TCON, 32'd0);

        // Overflow with interrupt disabled, then CPU write to TL on overflow cycle
        wr(A_TL, 32'hFFFFFFFE);
        wr(A_TCON, 32'd1);
        step(); step();
        rd(A_TL, r); chk("tl_reload_noie", r, 32'hFFFFFFFD);
        chk("irq_noie", {31'd0, oIrq}, 32'd0);
        step(); step();
        rd(A_TL, r); chk("tl_at_ff", r, 32'hFFFFFFFF);
        wr(A_TL, 32'h00000010);
        rd(A_TL, r); chk("tl_write_wins", r, 32'h00000010);
        wr(A_TCON, 32'd0);

        // TCON write on the overflow cycle wins, including bit2
        wr(A_TL, 32'hFFFFFFFE);
        wr(A_TCON, 32'd3);
        step();
        wr(A_TCON, 32'd3);
        chk("tcon_write_wins", {31'd0, oIrq}, 32'd0);
        rd(A_TL, r); chk("tl_reload2", r, 32'hFFFFFFFD);
        wr(A_TCON, 32'd0);

        // UART frame 0x55 with a dropped write while busy
        wr(A_TXD, 32'h155);
        for (int i = 0; i < 40; i++) begin
            if (i == 8) begin
                bus.iAddr = A_TXD; bus.iWrData = 32'h33; bus.iMemWrite = 1'b1; bus.iMemRead = 1'b0;
                #1;
            end else begin
                rd(A_STAT, r); chk("uart_busy", r, 32'd1);
            end
            chk("uart_bit55", {31'd0, oTx}, {31'd0, pat55[i/N]});
            step();
            bus.iMemWrite = 1'b0;
        end
        rd(A_STAT, r); chk("uart_done", r, 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("uart_no_second", {31'd0, oTx}, 32'd1);
            step();
        end

        // Reset asserted mid-frame
        wr(A_LED, 32'h3C);
        wr(A_TXD, 32'hA3);
        repeat (5) step();
        rd(A_STAT, r);
        #1;
        iRst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, oTx}, 32'd1);
        chk("midrst_busy", bus.oRdData, 32'd0);
        chk("midrst_led", {24'd0, oLed}, 32'd0);
        step();
        iRst_n = 1'b1;
        step();
        wr(A_TXD, 32'h0F);
        for (int i = 0; i < 40; i++) begin
            chk("uart_bit0f", {31'd0, oTx}, {31'd0, pat0f[i/N]});
            step();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.iAddr     = rand_addr();
            bus.iMemRead  = 1'($urandom_range(0, 1));
            bus.iMemWrite = ($urandom_range(0, 3) == 0);
            bus.iWrData   = $urandom_range(0, 1) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom();
            if ($urandom_range(0, 7) == 0) iSwitch = 8'($urandom());
            step();
        end
        bus.iMemWrite = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
